ocidec1_host_if: RTL and testbench
==================================

# ocidec1_host_if

Wishbone slave front-end for the OCIDEC1 ATA host. It sits directly upstream of the OCIDEC1 controller core and holds the control, status and PIO timing registers that the core consumes. It converts Wishbone accesses in the ATA register window into single PIOreq/PIOack transactions, and returns captured ATA read data to the bus.

## Interface
Parameters:
- PIO_mode0_T1, 6, reset value of the T1 timing field (70 ns @100 MHz)
- PIO_mode0_T2, 28, reset value of the T2 timing field
- PIO_mode0_T4, 2, reset value of the T4 timing field
- PIO_mode0_Teoc, 23, reset value of the Teoc timing field

Ports:
- clk  in  1  master clock
- nReset  in  1  asynchronous reset, active low
- rst  in  1  synchronous reset, active high; same effect as nReset
- wb_adr_i  in  5  word address (byte address bits [6:2])
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, registered
- wb_sel_i  in  4  byte lane selects
- wb_we_i  in  1  1 = write
- wb_stb_i, wb_cyc_i  in  1  strobe and cycle
- wb_ack_o  out  1  transfer acknowledge, one-cycle pulse
- wb_err_o  out  1  error acknowledge, one-cycle pulse
- inta_o  out  1  interrupt output
- irq  in  1  synchronized INTRQ from the core
- IDEctrl_rst, IDEctrl_IDEen, PIO_cmdport_IORDYen  out  1  control bits to the core
- PIO_cmdport_T1/T2/T4/Teoc  out  8 each  timing fields to the core
- PIOreq  out  1  PIO transfer request
- PIOa  out  4  ATA register address {CS1-select, DA[2:0]}
- PIOd  out  16  PIO write data
- PIOwe  out  1  1 = write, 0 = read
- PIOack  in  1  core completion; may be asserted in the same cycle PIOreq is first seen
- PIOq  in  16  ATA read data, valid in the PIOack cycle

## Operation
- Address map (byte address):
  - 0x00 CTRL (rw):
    - bit0 IDEctrl_rst, reset value 1.
    - bit1 IORDYen, reset value 0.
    - bit2 IRQen, reset value 0.
    - bit7 IDEen, reset value 0.
    - Other bits read 0.
    - Only byte lane 0 is writable.
  - 0x04 STAT (ro):
    - bit0 irq level.
    - bit1 PIO busy (FSM not in IDLE).
    - bits[31:24] = 8'h01 (device ID).
    - Writes are acked and ignored.
  - 0x08 PIOTIM (rw): T1[7:0], T2[15:8], T4[23:16], Teoc[31:24]. Per-byte writes via wb_sel_i. Reset value {Teoc, T4, T2, T1} from the parameters.
  - 0x0C–0x3C: unmapped; access returns wb_err_o.
  - 0x40–0x7C: ATA window. PIOa = wb_adr_i[3:0]; PIOd = wb_dat_i[15:0]. Reads return {16'h0, PIOq}.
- Control outputs drive combinationally from the register bits.
- inta_o = irq & IRQen.
- FSM states:
  - IDLE:
    - Internal register access: ack or err next cycle, return to IDLE.
    - ATA access with IDEen=1: latch PIOa/PIOd/PIOwe and go to PIO.
    - ATA access with IDEen=0: wb_err_o next cycle; no PIOreq is issued.
  - PIO:
    - PIOreq=1; PIOa/PIOd/PIOwe stay stable.
    - On PIOack: latch PIOq into wb_dat_o (reads), drop PIOreq at the next edge, pulse wb_ack_o, go to DONE.
  - DONE: one cycle with wb_ack_o=0, then IDLE. This guarantees no double-ack while the master samples ack and drops stb.
- Bus abort: if wb_cyc_i drops while in PIO, the ATA cycle still completes (PIOreq held until PIOack), and wb_ack_o is suppressed.
- wb_ack_o and wb_err_o are never asserted together.

## Timing
- Reset (nReset low or rst high) values:
  - wb_ack_o=0, wb_err_o=0, wb_dat_o=0, PIOreq=0, PIOa=0, PIOd=0, PIOwe=0.
  - IDEctrl_rst=1, IDEctrl_IDEen=0, IORDYen=0, inta_o=0.
  - Timing fields = parameter values; FSM = IDLE.
- Register access: stb sampled at edge N; wb_ack_o high during cycle N+1; write takes effect at edge N+1. Latency 1 cycle.
- PIO access:
  - stb sampled at edge N; PIOreq rises after edge N.
  - If PIOack is first seen at edge M: PIOreq=0, wb_ack_o=1 and wb_dat_o=PIOq, all valid after edge M.
  - Total latency is the core latency + 1 cycle.
- The next request is accepted no earlier than 2 cycles after the ack (via DONE).
- Reset mid-PIO: PIOreq drops immediately (async) or at the next edge (rst); no ack is issued.

## Test plan
- Reset: read 0x00 -> 32'h0000_0001; read 0x08 -> 32'h1702_1C06; read 0x04 -> 32'h0100_0000. Each ack arrives 1 cycle after stb.
- Write 0x08 with data 32'hAABB_CCDD, sel=4'b0101 -> readback 32'h17BB_1CDD; PIO_cmdport_T2 = 8'h1C.
- Write CTRL = 0x80, then read 0x5C with a model that acks after 10 cycles returning 16'h1234:
  - PIOa = 4'h7, PIOwe = 0.
  - PIOreq stays high until the ack.
  - wb_dat_o = 32'h0000_1234 with a single ack pulse.
- With IDEen=1, write 16'hBEEF to 0x40 -> PIOa=0, PIOd=16'hBEEF, PIOwe=1. Then drop cyc mid-transfer -> PIOreq held to PIOack, no wb_ack_o.
- With IDEen=0, access 0x40 -> wb_err_o pulse, PIOreq never asserted. Access 0x20 -> wb_err_o pulse.
- irq=1 with IRQen=0 -> inta_o=0 and STAT bit0=1. Set IRQen=1 -> inta_o=1. Assert rst -> inta_o=0 and CTRL reverts to 0x01.

Source files
------------

// File: rtl/ocidec1_host_if.sv
// Wishbone slave front-end for the OCIDEC1 ATA host: control/status/timing
// registers plus translation of ATA-window accesses into PIOreq/PIOack cycles.
module ocidec1_host_if #(
  parameter logic [7:0] PIO_mode0_T1   = 8'd6,
  parameter logic [7:0] PIO_mode0_T2   = 8'd28,
  parameter logic [7:0] PIO_mode0_T4   = 8'd2,
  parameter logic [7:0] PIO_mode0_Teoc = 8'd23
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        rst,
  input  logic [4:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        inta_o,
  input  logic        irq,
  output logic        IDEctrl_rst,
  output logic        IDEctrl_IDEen,
  output logic        PIO_cmdport_IORDYen,
  output logic [7:0]  PIO_cmdport_T1,
  output logic [7:0]  PIO_cmdport_T2,
  output logic [7:0]  PIO_cmdport_T4,
  output logic [7:0]  PIO_cmdport_Teoc,
  output logic        PIOreq,
  output logic [3:0]  PIOa,
  output logic [15:0] PIOd,
  output logic        PIOwe,
  input  logic        PIOack,
  input  logic [15:0] PIOq
);

  // state | meaning
  // IDLE  | waiting for a bus request; register accesses complete from here
  // PIO   | PIOreq held to the core until PIOack
  // DONE  | one dead cycle after the PIO ack so the master can drop stb
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PIO  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [31:0] TIM_RST = {PIO_mode0_Teoc, PIO_mode0_T4, PIO_mode0_T2, PIO_mode0_T1};

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_ack;
  logic        r_err;
  logic [31:0] r_dat;
  logic        r_abort;
  logic        r_pioreq;
  logic [3:0]  r_pioa;
  logic [15:0] r_piod;
  logic        r_piowe;

  logic        r_ctrl_rst;
  logic        r_iordyen;
  logic        r_irqen;
  logic        r_ideen;
  logic [31:0] r_tim;

  logic        w_req;
  logic        w_ata;
  logic        w_reg_hit;
  logic        w_reg_acc;
  logic        w_err_acc;
  logic        w_pio_start;
  logic        w_pio_done;
  logic [31:0] w_rd_data;

  // A request is ignored while its own ack/err is still on the bus.
  assign w_req     = wb_stb_i & wb_cyc_i & ~r_ack & ~r_err;
  assign w_ata     = wb_adr_i[4];
  assign w_reg_hit = ~w_ata & (wb_adr_i[3:0] < 4'd3);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;
    end else if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_reg_acc   = 1'b0;
    w_err_acc   = 1'b0;
    w_pio_start = 1'b0;
    w_pio_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_ata && r_ideen) begin
            w_pio_start = 1'b1;
            w_state_nxt = S_PIO;
          end else if (w_reg_hit) begin
            w_reg_acc = 1'b1;
          end else begin
            w_err_acc = 1'b1;
          end
        end
      end
      S_PIO: begin
        if (PIOack) begin
          w_pio_done  = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_rd_data = 32'h0;
    case (wb_adr_i[1:0])
      2'd0:    w_rd_data = {24'h0, r_ideen, 4'b0000, r_irqen, r_iordyen, r_ctrl_rst};
      2'd1:    w_rd_data = {8'h01, 22'h0, (r_state != S_IDLE), irq};
      2'd2:    w_rd_data = r_tim;
      default: w_rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_dat    <= 32'h0;
      r_abort  <= 1'b0;
      r_pioreq <= 1'b0;
      r_pioa   <= 4'h0;
      r_piod   <= 16'h0;
      r_piowe  <= 1'b0;
    end else if (rst) begin
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_dat    <= 32'h0;
      r_abort  <= 1'b0;
      r_pioreq <= 1'b0;
      r_pioa   <= 4'h0;
      r_piod   <= 16'h0;
      r_piowe  <= 1'b0;
    end else begin
      // An aborted bus cycle still finishes on the ATA side but is never acked.
      r_ack <= w_reg_acc | (w_pio_done & wb_cyc_i & ~r_abort);
      r_err <= w_err_acc;
      if (w_pio_start) begin
        r_abort <= 1'b0;
      end else if (r_state == S_PIO && !wb_cyc_i) begin
        r_abort <= 1'b1;
      end
      if (w_reg_acc && !wb_we_i) begin
        r_dat <= w_rd_data;
      end else if (w_pio_done && !r_piowe) begin
        r_dat <= {16'h0, PIOq};
      end
      if (w_pio_start) begin
        r_pioreq <= 1'b1;
        r_pioa   <= wb_adr_i[3:0];
        r_piod   <= wb_dat_i[15:0];
        r_piowe  <= wb_we_i;
      end else if (w_pio_done) begin
        r_pioreq <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_ctrl_rst <= 1'b1;
      r_iordyen  <= 1'b0;
      r_irqen    <= 1'b0;
      r_ideen    <= 1'b0;
      r_tim      <= TIM_RST;
    end else if (rst) begin
      r_ctrl_rst <= 1'b1;
      r_iordyen  <= 1'b0;
      r_irqen    <= 1'b0;
      r_ideen    <= 1'b0;
      r_tim      <= TIM_RST;
    end else if (w_reg_acc && wb_we_i) begin
      if (wb_adr_i[1:0] == 2'd0 && wb_sel_i[0]) begin
        r_ctrl_rst <= wb_dat_i[0];
        r_iordyen  <= wb_dat_i[1];
        r_irqen    <= wb_dat_i[2];
        r_ideen    <= wb_dat_i[7];
      end
      if (wb_adr_i[1:0] == 2'd2) begin
        for (int b = 0; b < 4; b++) begin
          if (wb_sel_i[b]) r_tim[8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

  assign wb_ack_o            = r_ack;
  assign wb_err_o            = r_err;
  assign wb_dat_o            = r_dat;
  assign inta_o              = irq & r_irqen;
  assign IDEctrl_rst         = r_ctrl_rst;
  assign IDEctrl_IDEen       = r_ideen;
  assign PIO_cmdport_IORDYen = r_iordyen;
  assign PIO_cmdport_T1      = r_tim[7:0];
  assign PIO_cmdport_T2      = r_tim[15:8];
  assign PIO_cmdport_T4      = r_tim[23:16];
  assign PIO_cmdport_Teoc    = r_tim[31:24];
  assign PIOreq              = r_pioreq;
  assign PIOa                = r_pioa;
  assign PIOd                = r_piod;
  assign PIOwe               = r_piowe;

endmodule

// File: tb/tb_ocidec1_host_if.sv
// Directed bench for ocidec1_host_if: a register/bus-level model plus a
// per-cycle comparer, with literal expectations pinning the model.
module tb_ocidec1_host_if;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        inta_o;
  logic        irq = 1'b0;
  logic        IDEctrl_rst;
  logic        IDEctrl_IDEen;
  logic        PIO_cmdport_IORDYen;
  logic [7:0]  PIO_cmdport_T1;
  logic [7:0]  PIO_cmdport_T2;
  logic [7:0]  PIO_cmdport_T4;
  logic [7:0]  PIO_cmdport_Teoc;
  logic        PIOreq;
  logic [3:0]  PIOa;
  logic [15:0] PIOd;
  logic        PIOwe;
  logic        PIOack = 1'b0;
  logic [15:0] PIOq = '0;

  ocidec1_host_if dut (
    .clk(clk), .nReset(nReset), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .inta_o(inta_o), .irq(irq),
    .IDEctrl_rst(IDEctrl_rst), .IDEctrl_IDEen(IDEctrl_IDEen),
    .PIO_cmdport_IORDYen(PIO_cmdport_IORDYen),
    .PIO_cmdport_T1(PIO_cmdport_T1), .PIO_cmdport_T2(PIO_cmdport_T2),
    .PIO_cmdport_T4(PIO_cmdport_T4), .PIO_cmdport_Teoc(PIO_cmdport_Teoc),
    .PIOreq(PIOreq), .PIOa(PIOa), .PIOd(PIOd), .PIOwe(PIOwe),
    .PIOack(PIOack), .PIOq(PIOq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [7:0]  m_ctrl;
  logic [31:0] m_tim;
  logic [31:0] rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 8'h01;
    m_tim  = {8'd23, 8'd2, 8'd28, 8'd6};
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] adr);
    case (adr)
      5'd0:    return {24'h0, m_ctrl};
      5'd1:    return {8'h01, 23'h0, irq};
      5'd2:    return m_tim;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (adr == 5'd0 && sel[0]) m_ctrl = dat[7:0] & 8'h87;
    if (adr == 5'd2) begin
      for (int b = 0; b < 4; b++) if (sel[b]) m_tim[8*b +: 8] = dat[8*b +: 8];
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctl_rst", 32'(IDEctrl_rst), 32'(m_ctrl[0]));
      chk("ctl_iordy", 32'(PIO_cmdport_IORDYen), 32'(m_ctrl[1]));
      chk("ctl_ideen", 32'(IDEctrl_IDEen), 32'(m_ctrl[7]));
      chk("timing", {PIO_cmdport_Teoc, PIO_cmdport_T4, PIO_cmdport_T2, PIO_cmdport_T1}, m_tim);
      chk("inta", 32'(inta_o), 32'(irq & m_ctrl[2]));
      chk("ack_err_excl", 32'(wb_ack_o & wb_err_o), 32'h0);
    end
  end

  // One Wishbone access; the model decides whether it is a register access,
  // an error, or a PIO transfer whose core acks lat cycles after PIOreq rises.
  task automatic bus(input logic [4:0] adr, input logic we, input logic [31:0] dat,
                     input logic [3:0] sel, input int lat, input logic [15:0] q,
                     input bit abort, output logic [31:0] rdata);
    logic [31:0] exp;
    bit is_pio;
    bit is_reg;
    is_reg = (adr < 5'd3);
    is_pio = adr[4] && m_ctrl[7];
    exp = model_read(adr);
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat; wb_sel_i = sel;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(posedge clk); #1;
    rdata = wb_dat_o;
    if (is_reg) begin
      chk("reg_ack", 32'(wb_ack_o), 32'h1);
      chk("reg_err", 32'(wb_err_o), 32'h0);
      if (!we) chk("reg_rd", wb_dat_o, exp);
      else model_write(adr, dat, sel);
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
      @(posedge clk); #1;
      chk("reg_ack_pulse", 32'({wb_ack_o, wb_err_o}), 32'h0);
    end else if (!is_pio) begin
      chk("err_err", 32'(wb_err_o), 32'h1);
      chk("err_ack", 32'(wb_ack_o), 32'h0);
      chk("err_noreq", 32'(PIOreq), 32'h0);
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
      @(posedge clk); #1;
      chk("err_pulse", 32'({wb_ack_o, wb_err_o}), 32'h0);
      chk("err_noreq2", 32'(PIOreq), 32'h0);
    end else begin
      chk("pio_req", 32'(PIOreq), 32'h1);
      chk("pio_a", 32'(PIOa), 32'(adr[3:0]));
      chk("pio_d", 32'(PIOd), 32'(dat[15:0]));
      chk("pio_we", 32'(PIOwe), 32'(we));
      chk("pio_noack", 32'(wb_ack_o), 32'h0);
      for (int i = 1; i < lat; i++) begin
        if (abort && i == 2) begin
          wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        end
        @(posedge clk); #1;
        chk("pio_req_hold", 32'(PIOreq), 32'h1);
        chk("pio_stable", {PIOwe, 11'h0, PIOa, PIOd}, {we, 11'h0, adr[3:0], dat[15:0]});
        chk("pio_noack_wait", 32'(wb_ack_o), 32'h0);
      end
      PIOack = 1'b1; PIOq = q;
      @(posedge clk); #1;
      PIOack = 1'b0; PIOq = 16'h5A5A;
      rdata = wb_dat_o;
      chk("pio_req_drop", 32'(PIOreq), 32'h0);
      chk("pio_ack", 32'(wb_ack_o), abort ? 32'h0 : 32'h1);
      if (!we && !abort) chk("pio_rd", wb_dat_o, {16'h0, q});
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
      @(posedge clk); #1;
      chk("pio_done_noack", 32'(wb_ack_o), 32'h0);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {wb_dat_o}, 32'h0);
    chk("rst_bits", 32'({wb_ack_o, wb_err_o, PIOreq, PIOwe, inta_o, IDEctrl_IDEen, PIO_cmdport_IORDYen, IDEctrl_rst}), 32'h01);
    chk("rst_pio", 32'({PIOa, PIOd}), 32'h0);
    nReset = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    bus(5'd0, 1'b0, 32'h0, 4'hF, 0, 16'h0, 1'b0, rd);
    chk("lit_ctrl_rst", rd, 32'h0000_0001);
    bus(5'd2, 1'b0, 32'h0, 4'hF, 0, 16'h0, 1'b0, rd);
    chk("lit_tim_rst", rd, 32'h1702_1C06);
    bus(5'd1, 1'b0, 32'h0, 4'hF, 0, 16'h0, 1'b0, rd);
    chk("lit_stat_rst", rd, 32'h0100_0000);

    bus(5'd2, 1'b1, 32'hAABB_CCDD, 4'b0101, 0, 16'h0, 1'b0, rd);
    bus(5'd2, 1'b0, 32'h0, 4'hF, 0, 16'h0, 1'b0, rd);
    chk("lit_tim_wr", rd, 32'h17BB_1CDD);
    chk("lit_t2", 32'(PIO_cmdport_T2), 32'h1C);
    bus(5'd1, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 16'h0, 1'b0, rd);

    bus(5'd0, 1'b1, 32'h0000_0080, 4'hF, 0, 16'h0, 1'b0, rd);
    chk("lit_ideen", 32'(IDEctrl_IDEen), 32'h1);
    bus(5'h17, 1'b0, 32'h0, 4'hF, 10, 16'h1234, 1'b0, rd);
    chk("lit_ata_rd", rd, 32'h0000_1234);
    bus(5'h1A, 1'b0, 32'h0, 4'hF, 1, 16'hABCD, 1'b0, rd);
    bus(5'h10, 1'b1, 32'h0000_BEEF, 4'hF, 4, 16'h0, 1'b0, rd);
    bus(5'h10, 1'b1, 32'h0000_1111, 4'hF, 6, 16'h0, 1'b1, rd);
    bus(5'h1F, 1'b1, 32'h0000_2222, 4'hF, 3, 16'h0, 1'b0, rd);

    bus(5'd0, 1'b1, 32'h0000_0003, 4'hF, 0, 16'h0, 1'b0, rd);
    bus(5'h10, 1'b0, 32'h0, 4'hF, 2, 16'h0, 1'b0, rd);
    bus(5'h08, 1'b0, 32'h0, 4'hF, 0, 16'h0, 1'b0, rd);
    bus(5'h03, 1'b1, 32'h0, 4'hF, 0, 16'h0, 1'b0, rd);

    irq = 1'b1;
    bus(5'd1, 1'b0, 32'h0, 4'hF, 0, 16'h0, 1'b0, rd);
    chk("lit_stat_irq", rd, 32'h0100_0001);
    chk("lit_inta_off", 32'(inta_o), 32'h0);
    bus(5'd0, 1'b1, 32'h0000_0004, 4'hF, 0, 16'h0, 1'b0, rd);
    chk("lit_inta_on", 32'(inta_o), 32'h1);
    bus(5'd0, 1'b1, 32'h0000_0000, 4'b1110, 0, 16'h0, 1'b0, rd);

    chk_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("lit_inta_rst", 32'(inta_o), 32'h0);
    chk_en = 1'b1;
    bus(5'd0, 1'b0, 32'h0, 4'hF, 0, 16'h0, 1'b0, rd);
    chk("lit_ctrl_after_rst", rd, 32'h0000_0001);
    bus(5'd2, 1'b0, 32'h0, 4'hF, 0, 16'h0, 1'b0, rd);
    chk("lit_tim_after_rst", rd, 32'h1702_1C06);

    bus(5'd0, 1'b1, 32'h0000_0080, 4'hF, 0, 16'h0, 1'b0, rd);
    wb_adr_i = 5'h11; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(posedge clk); #1;
    chk("arst_req_up", 32'(PIOreq), 32'h1);
    @(posedge clk); #1;
    chk_en = 1'b0;
    nReset = 1'b0;
    #1;
    chk("arst_req_drop", 32'(PIOreq), 32'h0);
    chk("arst_noack", 32'(wb_ack_o), 32'h0);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    @(posedge clk); #1;
    nReset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk_en = 1'b1;
    chk("arst_idle", 32'({PIOreq, wb_ack_o, wb_err_o}), 32'h0);
    irq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
